// File: rtl/division_pkg.sv
// Shared ALU definitions for the divider.
// Data width default, FSM states, divide-by-zero result.
package division_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/division_if.sv
// Start/Busy/Done handshake and operand/result bus
// between the ALU sequencer (master) and the divider (slave).
interface division_if
  import division_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, A, B,
    input  Quotient, Remainder,
    input  DivByZero, Busy, Done
  );

  modport slave (
    input  Start, A, B,
    output Quotient, Remainder,
    output DivByZero, Busy, Done
  );

endinterface

// File: rtl/division_step.sv
// One radix-2 restoring divide step:
// shift {rem,q} left, trial-subtract b, restore on borrow.
module division_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH:0] sh;
  logic           ge;

  // Upper WIDTH+1 bits keep the carry when b has its MSB set.
  always_comb begin
    sh = {rem, q[WIDTH-1]};
    ge = (sh >= {1'b0, b});
    if (ge) begin
      rem_n = WIDTH'(sh - {1'b0, b});
      q_n   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = sh[WIDTH-1:0];
      q_n   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/division.sv
// Iterative unsigned divider, one quotient bit per clock.
// B==0 answers at the accept edge with all-ones / A.
module division
  import division_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  division_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rmd_r;
  logic             dz_r;
  logic             done_r;
  logic             accept;
  logic             b_zero;
  logic             last;

  division_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem  (rem),
    .q    (q),
    .b    (b_r),
    .rem_n(rem_n),
    .q_n  (q_n)
  );

  // Next state: accept only when idle; leave RUN on last step.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    b_zero  = (bus.B == '0);
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          accept = 1'b1;
          if (!b_zero) state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          last    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath, counter and result registers; results hold during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      q      <= '0;
      b_r    <= '0;
      quo_r  <= '0;
      rmd_r  <= '0;
      dz_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        if (b_zero) begin
          quo_r  <= '1;
          rmd_r  <= bus.A;
          dz_r   <= 1'b1;
          done_r <= 1'b1;
        end else begin
          rem <= '0;
          q   <= bus.A;
          b_r <= bus.B;
          cnt <= CW'(WIDTH);
        end
      end else if (state == RUN) begin
        rem <= rem_n;
        q   <= q_n;
        cnt <= cnt - CW'(1);
        if (last) begin
          quo_r  <= q_n;
          rmd_r  <= rem_n;
          dz_r   <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.Quotient  = quo_r;
  assign bus.Remainder = rmd_r;
  assign bus.DivByZero = dz_r;
  assign bus.Busy      = (state == RUN);
  assign bus.Done      = done_r;

endmodule

// File: tb/tb_division.sv
// Self-checking bench for division against an
// arithmetic reference model with random sweeps.
module tb_division;
  import division_pkg::*;

  localparam int W = DIV_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  division_if #(.WIDTH(W)) bus ();

  division #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dz = 1'b0;

  logic [W-1:0] oq;
  logic [W-1:0] orr;
  logic         odz;
  int           olat;
  int           obusy;
  bit           ohold;

  function automatic void model(input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] q,
                                output logic [W-1:0] r,
                                output logic dz);
    if (b == 0) begin
      q = DIV_ZERO_Q; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Drives one divide from a negedge; returns at the negedge where
  // Done is seen. poke>=0 re-pulses Start with 1/1 mid-run.
  task automatic run_div(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input int poke);
    bit done;
    logic [W-1:0] mq, mr;
    logic mdz;
    done = 0;
    bus.Start = 1'b1; bus.A = a; bus.B = b;
    ohold = 1; obusy = 0; olat = -1;
    oq = 'x; orr = 'x; odz = 1'bx;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 0) bus.Start = 1'b0;
      if (poke >= 0 && i == poke) begin
        bus.Start = 1'b1; bus.A = 1; bus.B = 1;
      end
      if (poke >= 0 && i == poke + 1) begin
        bus.Start = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom);
      end
      if (bus.Busy === 1'b1) obusy++;
      if (bus.Done === 1'b1) begin
        done = 1; olat = i;
        oq = bus.Quotient; orr = bus.Remainder; odz = bus.DivByZero;
      end else if (bus.Quotient !== last_q ||
                   bus.Remainder !== last_r ||
                   bus.DivByZero !== last_dz) begin
        ohold = 0;
      end
    end
    bus.Start = 1'b0;
    model(a, b, mq, mr, mdz);
    last_q = mq; last_r = mr; last_dz = mdz;
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.Quotient, bus.Remainder, bus.DivByZero, bus.Busy, bus.Done}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h dz=%b busy=%b done=%b, want all 0",
               bus.Quotient, bus.Remainder, bus.DivByZero, bus.Busy, bus.Done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    run_div(0, 0, -1);
    checks++;
    if (oq !== 16'hFFFF || orr !== 0 || odz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got q=%h r=%h dz=%b, want ffff 0 1", oq, orr, odz);
    end
    checks++;
    if (olat !== 0 || obusy !== 0) begin
      errors++;
      $display("FAIL dbz_timing: got lat=%0d busy=%0d, want 0 0", olat, obusy);
    end
  endtask

  task automatic test_basic();
    run_div(5, 2, -1);
    checks++;
    if (oq !== 2 || orr !== 1 || odz !== 1'b0) begin
      errors++;
      $display("FAIL basic_5_2: got q=%0d r=%0d dz=%b, want 2 1 0", oq, orr, odz);
    end
    checks++;
    if (olat !== 16 || obusy !== 16 || !ohold) begin
      errors++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d hold=%0d, want 16 16 1",
               olat, obusy, ohold);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] divs [3] = '{3, 4, 5};
    logic [W-1:0] eq [3] = '{6, 4, 3};
    logic [W-1:0] er [3] = '{0, 2, 3};
    for (int k = 0; k < 3; k++) begin
      run_div(18, divs[k], -1);
      checks++;
      if (oq !== eq[k] || orr !== er[k] || olat !== 16 || !ohold) begin
        errors++;
        $display("FAIL b2b_18_%0d: got q=%0d r=%0d lat=%0d hold=%0d, want %0d %0d 16 1",
                 divs[k], oq, orr, olat, ohold, eq[k], er[k]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [4] = '{16'hFFFF, 16'hFFFF, 7, 0};
    logic [W-1:0] tb [4] = '{1, 16'h8000, 9, 13};
    logic [W-1:0] tq [4] = '{16'hFFFF, 1, 0, 0};
    logic [W-1:0] tr [4] = '{0, 16'h7FFF, 7, 0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      run_div(ta[k], tb[k], -1);
      checks++;
      if (oq !== tq[k] || orr !== tr[k] || odz !== 1'b0 || olat !== 16) begin
        errors++;
        $display("FAIL bound_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d, want %0d %0d 0 16",
                 ta[k], tb[k], oq, orr, odz, olat, tq[k], tr[k]);
      end
    end
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    run_div(100, 7, 4);
    checks++;
    if (oq !== 14 || orr !== 2 || olat !== 16 || !ohold) begin
      errors++;
      $display("FAIL ignored_start: got q=%0d r=%0d lat=%0d hold=%0d, want 14 2 16 1",
               oq, orr, olat, ohold);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, mq, mr;
    logic mdz;
    int bad_model, bad_inv, bad_lat;
    bad_model = 0; bad_inv = 0; bad_lat = 0;
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15))
                                      : W'($urandom);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      model(a, b, mq, mr, mdz);
      run_div(a, b, -1);
      checks++;
      if (oq !== mq || orr !== mr || odz !== mdz) begin
        errors++;
        if (bad_model++ < 5)
          $display("FAIL rand_result: %0d/%0d got q=%0d r=%0d dz=%b, want %0d %0d %b",
                   a, b, oq, orr, odz, mq, mr, mdz);
      end
      if (b != 0) begin
        checks++;
        if (32'(oq) * 32'(b) + 32'(orr) !== 32'(a) || !(orr < b)) begin
          errors++;
          if (bad_inv++ < 5)
            $display("FAIL rand_invariant: %0d/%0d got q=%0d r=%0d", a, b, oq, orr);
        end
      end
      checks++;
      if (olat !== ((b == 0) ? 0 : 16) || !ohold) begin
        errors++;
        if (bad_lat++ < 5)
          $display("FAIL rand_latency: %0d/%0d got lat=%0d hold=%0d, want %0d 1",
                   a, b, olat, ohold, (b == 0) ? 0 : 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 1000; bus.B = 3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.Quotient, bus.Remainder, bus.DivByZero, bus.Busy, bus.Done}
        !== '0) begin
      errors++;
      $display("FAIL async_reset: got q=%h r=%h dz=%b busy=%b done=%b, want all 0",
               bus.Quotient, bus.Remainder, bus.DivByZero, bus.Busy, bus.Done);
    end
    last_q = '0; last_r = '0; last_dz = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d cycles with Done/Busy after reset, want 0", seen);
    end
    run_div(9, 3, -1);
    checks++;
    if (oq !== 3 || orr !== 0 || olat !== 16 || !ohold) begin
      errors++;
      $display("FAIL post_reset: got q=%0d r=%0d lat=%0d hold=%0d, want 3 0 16 1",
               oq, orr, olat, ohold);
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    test_reset();
    test_div_by_zero();
    @(negedge clk);
    test_basic();
    test_back_to_back();
    test_boundaries();
    test_ignored_start();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
